// File: rtl/p07_colour_sequencer_if.sv
// p07_colour_sequencer_if
//   Bundle between the colour sequencer and its surroundings.
//   master: drives mode, prescale, period pulse and encoder targets;
//           receives the PWM levels, FSM state and busy flag.
//   slave : the sequencer side (inputs and outputs reversed).
//   Signals: auto_en, tick_div, period_start, target0..2 (to sequencer)
//            level0..2, state, busy                      (from sequencer)
interface p07_colour_sequencer_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
);
  logic                  auto_en;
  logic [PRESCALE_W-1:0] tick_div;
  logic                  period_start;
  logic [WIDTH-1:0]      target0;
  logic [WIDTH-1:0]      target1;
  logic [WIDTH-1:0]      target2;
  logic [WIDTH-1:0]      level0;
  logic [WIDTH-1:0]      level1;
  logic [WIDTH-1:0]      level2;
  logic [2:0]            state;
  logic                  busy;

  modport master (
    output auto_en, tick_div, period_start, target0, target1, target2,
    input  level0, level1, level2, state, busy
  );

  modport slave (
    input  auto_en, tick_div, period_start, target0, target1, target2,
    output level0, level1, level2, state, busy
  );
endinterface

// File: rtl/p07_colour_sequencer.sv
// p07_colour_sequencer
//   Level controller between three rotary-encoder counters and the three
//   PWM channels of an RGB mixer. MANUAL mode slews each level one LSB per
//   step toward its encoder target; AUTO mode walks a six-phase hue wheel.
//   Level updates are committed only on a PWM period boundary.
// Ports
//   clk    : system clock
//   rst_n  : asynchronous reset, active low
//   bus    : p07_colour_sequencer_if.slave
//            in : auto_en, tick_div, period_start, target0..2
//            out: level0..2 (registered), state (0-5 phase, 6 MANUAL,
//                 7 AUTO_INIT), busy (MANUAL and any level != target)
module p07_colour_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  p07_colour_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    PH0       = 3'd0,
    PH1       = 3'd1,
    PH2       = 3'd2,
    PH3       = 3'd3,
    PH4       = 3'd4,
    PH5       = 3'd5,
    MANUAL    = 3'd6,
    AUTO_INIT = 3'd7
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MIN = '0;

  state_t                      st;
  state_t                      nxt_st;
  logic [PRESCALE_W-1:0]       count;
  logic                        step_pending;
  logic [2:0][WIDTH-1:0]       lvl;
  logic [2:0][WIDTH-1:0]       nxt;
  logic [2:0][WIDTH-1:0]       tgt;
  logic                        fire;
  logic                        apply;

  // One LSB toward the goal, saturating at the goal itself.
  function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] goal);
    if (cur < goal)      return cur + WIDTH'(1);
    else if (cur > goal) return cur - WIDTH'(1);
    else                 return cur;
  endfunction

  assign tgt   = {bus.target2, bus.target1, bus.target0};
  assign fire  = (count >= bus.tick_div);
  // A prescaler fire landing on the period pulse is consumed directly.
  assign apply = bus.period_start && (step_pending || fire);

  // Candidate levels/state for an apply cycle.
  always_comb begin
    nxt    = lvl;
    nxt_st = st;
    case (st)
      MANUAL: begin
        nxt[0] = slew(lvl[0], tgt[0]);
        nxt[1] = slew(lvl[1], tgt[1]);
        nxt[2] = slew(lvl[2], tgt[2]);
      end
      AUTO_INIT: begin
        nxt[0] = slew(lvl[0], MAX);
        nxt[1] = slew(lvl[1], MIN);
        nxt[2] = slew(lvl[2], MIN);
        if (nxt[0] == MAX && nxt[1] == MIN && nxt[2] == MIN) nxt_st = PH0;
      end
      PH0: begin
        nxt[1] = slew(lvl[1], MAX);
        if (nxt[1] == MAX) nxt_st = PH1;
      end
      PH1: begin
        nxt[0] = slew(lvl[0], MIN);
        if (nxt[0] == MIN) nxt_st = PH2;
      end
      PH2: begin
        nxt[2] = slew(lvl[2], MAX);
        if (nxt[2] == MAX) nxt_st = PH3;
      end
      PH3: begin
        nxt[1] = slew(lvl[1], MIN);
        if (nxt[1] == MIN) nxt_st = PH4;
      end
      PH4: begin
        nxt[0] = slew(lvl[0], MAX);
        if (nxt[0] == MAX) nxt_st = PH5;
      end
      PH5: begin
        nxt[2] = slew(lvl[2], MIN);
        if (nxt[2] == MIN) nxt_st = PH0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      step_pending <= 1'b0;
      lvl          <= '0;
      st           <= MANUAL;
    end else begin
      count <= fire ? '0 : count + PRESCALE_W'(1);

      if (apply)     step_pending <= 1'b0;
      else if (fire) step_pending <= 1'b1;

      // Mode switches take priority over a step: levels hold that cycle,
      // and any step due in that cycle is dropped rather than deferred.
      if (st == MANUAL && bus.auto_en) begin
        st <= AUTO_INIT;
      end else if (st != MANUAL && !bus.auto_en) begin
        st <= MANUAL;
      end else if (apply) begin
        lvl <= nxt;
        st  <= nxt_st;
      end
    end
  end

  assign bus.level0 = lvl[0];
  assign bus.level1 = lvl[1];
  assign bus.level2 = lvl[2];
  assign bus.state  = st;
  assign bus.busy   = (st == MANUAL) && (lvl != tgt);

endmodule
